// File: rtl/ls_multiple_seq.sv
// rtl/ls_multiple_seq.sv - load/store-multiple decode sequencer
// Expands one lmw/stmw into one memory beat per GPR from rt up to NUM_GPR-1.
module ls_multiple_seq #(
  parameter int GPR_W   = 5,
  parameter int NUM_GPR = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_is_store,
  input  logic [GPR_W-1:0] i_rt,
  input  logic             i_hold,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_if_hold,
  output logic             o_ls_en,
  output logic             o_ls_we,
  output logic             o_first_cycle,
  output logic             o_multiple_inc,
  output logic             o_last,
  output logic [GPR_W-1:0] o_gpr_idx,
  output logic             o_done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [GPR_W-1:0] LAST_IDX = GPR_W'(NUM_GPR - 1);
  localparam logic [GPR_W:0]   NUM_CNT  = (GPR_W+1)'(NUM_GPR);
  localparam logic [GPR_W:0]   CNT_ONE  = (GPR_W+1)'(1);
  localparam logic [GPR_W:0]   CNT_TWO  = (GPR_W+1)'(2);

  state_t           r_state, w_state_n;
  logic [GPR_W:0]   r_remain, w_remain_n;
  logic             r_ls_en, w_ls_en_n;
  logic             r_ls_we, w_ls_we_n;
  logic             r_first, w_first_n;
  logic             r_inc, w_inc_n;
  logic             r_last, w_last_n;
  logic [GPR_W-1:0] r_idx, w_idx_n;
  logic             r_done, w_done_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_remain <= '0;
      r_ls_en  <= 1'b0;
      r_ls_we  <= 1'b0;
      r_first  <= 1'b0;
      r_inc    <= 1'b0;
      r_last   <= 1'b0;
      r_idx    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_remain <= w_remain_n;
      r_ls_en  <= w_ls_en_n;
      r_ls_we  <= w_ls_we_n;
      r_first  <= w_first_n;
      r_inc    <= w_inc_n;
      r_last   <= w_last_n;
      r_idx    <= w_idx_n;
      r_done   <= w_done_n;
    end
  end

  // Defaults hold every register; done is a pulse and always falls unless re-fired.
  always_comb begin
    w_state_n  = r_state;
    w_remain_n = r_remain;
    w_ls_en_n  = r_ls_en;
    w_ls_we_n  = r_ls_we;
    w_first_n  = r_first;
    w_inc_n    = r_inc;
    w_last_n   = r_last;
    w_idx_n    = r_idx;
    w_done_n   = 1'b0;

    if (i_abort) begin
      w_state_n  = S_IDLE;
      w_remain_n = '0;
      w_ls_en_n  = 1'b0;
      w_ls_we_n  = 1'b0;
      w_first_n  = 1'b0;
      w_inc_n    = 1'b0;
      w_last_n   = 1'b0;
      w_idx_n    = '0;
    end else if (!i_hold) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_state_n  = S_RUN;
            w_remain_n = NUM_CNT - {1'b0, i_rt};
            w_ls_en_n  = 1'b1;
            w_ls_we_n  = i_is_store;
            w_first_n  = 1'b1;
            w_inc_n    = 1'b0;
            w_last_n   = (i_rt == LAST_IDX);
            w_idx_n    = i_rt;
          end
        end
        S_RUN: begin
          if (r_last) begin
            w_state_n  = S_IDLE;
            w_remain_n = '0;
            w_ls_en_n  = 1'b0;
            w_ls_we_n  = 1'b0;
            w_first_n  = 1'b0;
            w_inc_n    = 1'b0;
            w_last_n   = 1'b0;
            w_idx_n    = '0;
            w_done_n   = 1'b1;
          end else begin
            // The beat count, not the index, decides the final beat so the index never wraps.
            w_remain_n = r_remain - CNT_ONE;
            w_first_n  = 1'b0;
            w_inc_n    = 1'b1;
            w_last_n   = (r_remain == CNT_TWO);
            w_idx_n    = r_idx + GPR_W'(1);
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  assign o_busy         = (r_state == S_RUN);
  assign o_ls_en        = r_ls_en;
  assign o_ls_we        = r_ls_we;
  assign o_first_cycle  = r_first;
  assign o_multiple_inc = r_inc;
  assign o_last         = r_last;
  assign o_gpr_idx      = r_idx;
  assign o_done         = r_done;

  // Fetch is released already in the cycle of the last beat.
  assign o_if_hold = (i_start & ~o_busy & ~i_abort) | (o_busy & ~r_last & ~i_abort);

endmodule

// File: tb/tb_ls_multiple_seq.sv
// tb/tb_ls_multiple_seq.sv - directed self-checking bench for ls_multiple_seq
module tb_ls_multiple_seq;

  logic       clk = 1'b0;
  logic       reset_n, start, is_store, hold, abort;
  logic [4:0] rt;
  logic       busy, if_hold, ls_en, ls_we, first_cycle, multiple_inc, last, done;
  logic [4:0] gpr_idx;

  int total = 0;
  int bad   = 0;
  int beats = 0;

  always #5 clk = ~clk;

  ls_multiple_seq #(.GPR_W(5), .NUM_GPR(32)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_is_store(is_store),
    .i_rt(rt), .i_hold(hold), .i_abort(abort),
    .o_busy(busy), .o_if_hold(if_hold), .o_ls_en(ls_en), .o_ls_we(ls_we),
    .o_first_cycle(first_cycle), .o_multiple_inc(multiple_inc), .o_last(last),
    .o_gpr_idx(gpr_idx), .o_done(done)
  );

  // Packed view: {busy, if_hold, ls_en, ls_we, first, inc, last, done, idx}
  function automatic logic [12:0] ev(input int b, input int ih, input int en, input int we,
                                     input int fc, input int inc, input int ls, input int dn,
                                     input int idx);
    return {b[0], ih[0], en[0], we[0], fc[0], inc[0], ls[0], dn[0], idx[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {busy, if_hold, ls_en, ls_we, first_cycle, multiple_inc, last, done, gpr_idx};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_beat();
    if (ls_en && !hold) beats++;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; is_store = 1'b0; hold = 1'b0; abort = 1'b0; rt = '0;
    #2;
    chk("reset", ev(0,0,0,0,0,0,0,0,0));
    tick(); tick();
    reset_n = 1'b1;

    // 1: lmw rt=29
    tick(); start = 1'b1; is_store = 1'b0; rt = 5'd29; #1;
    chk("t1_c0_ifhold", ev(0,1,0,0,0,0,0,0,0));
    tick(); start = 1'b0; #1; chk("t1_b29", ev(1,1,1,0,1,0,0,0,29));
    tick(); #1; chk("t1_b30", ev(1,1,1,0,0,1,0,0,30));
    tick(); #1; chk("t1_b31", ev(1,0,1,0,0,1,1,0,31));
    tick(); #1; chk("t1_done", ev(0,0,0,0,0,0,0,1,0));
    tick(); #1; chk("t1_after", ev(0,0,0,0,0,0,0,0,0));

    // 2: stmw rt=31
    start = 1'b1; is_store = 1'b1; rt = 5'd31;
    tick(); start = 1'b0; is_store = 1'b0; #1; chk("t2_single", ev(1,0,1,1,1,0,1,0,31));
    tick(); #1; chk("t2_done", ev(0,0,0,0,0,0,0,1,0));

    // 3: lmw rt=28 with hold for t2..t4
    tick(); start = 1'b1; rt = 5'd28;
    tick(); start = 1'b0; #1; chk("t3_b28", ev(1,1,1,0,1,0,0,0,28)); count_beat();
    tick(); hold = 1'b1; #1; chk("t3_h2", ev(1,1,1,0,0,1,0,0,29)); count_beat();
    tick(); #1; chk("t3_h3", ev(1,1,1,0,0,1,0,0,29)); count_beat();
    tick(); #1; chk("t3_h4", ev(1,1,1,0,0,1,0,0,29)); count_beat();
    tick(); hold = 1'b0; #1; chk("t3_b29", ev(1,1,1,0,0,1,0,0,29)); count_beat();
    tick(); #1; chk("t3_b30", ev(1,1,1,0,0,1,0,0,30)); count_beat();
    tick(); #1; chk("t3_b31", ev(1,0,1,0,0,1,1,0,31)); count_beat();
    tick(); #1; chk("t3_done", ev(0,0,0,0,0,0,0,1,0));
    total++;
    assert (beats == 4) else begin
      bad++;
      $error("FAIL t3_beats observed=%0d required=4", beats);
    end

    // 4: lmw rt=0, abort with hold at beat 2, then rt=30
    tick(); start = 1'b1; rt = 5'd0;
    tick(); start = 1'b0; #1; chk("t4_b0", ev(1,1,1,0,1,0,0,0,0));
    tick(); #1; chk("t4_b1", ev(1,1,1,0,0,1,0,0,1));
    tick(); abort = 1'b1; hold = 1'b1; #1; chk("t4_abort", ev(1,0,1,0,0,1,0,0,2));
    tick(); abort = 1'b0; hold = 1'b0; #1; chk("t4_flushed", ev(0,0,0,0,0,0,0,0,0));
    tick(); start = 1'b1; rt = 5'd30; #1; chk("t4_nodone", ev(0,1,0,0,0,0,0,0,0));
    tick(); start = 1'b0; #1; chk("t4_b30", ev(1,1,1,0,1,0,0,0,30));
    tick(); #1; chk("t4_b31", ev(1,0,1,0,0,1,1,0,31));
    tick(); #1; chk("t4_done", ev(0,0,0,0,0,0,0,1,0));
    tick(); start = 1'b1; abort = 1'b1; rt = 5'd3; #1;
    chk("t4_abort_start", ev(0,0,0,0,0,0,0,0,0));
    tick(); start = 1'b0; abort = 1'b0; #1; chk("t4_start_dropped", ev(0,0,0,0,0,0,0,0,0));

    // 5: reset mid-sequence
    tick(); start = 1'b1; rt = 5'd10;
    tick(); start = 1'b0;
    repeat (4) tick();
    #1; chk("t5_b14", ev(1,1,1,0,0,1,0,0,14));
    reset_n = 1'b0; #1; chk("t5_async_rst", ev(0,0,0,0,0,0,0,0,0));
    tick(); reset_n = 1'b1;
    tick(); #1; chk("t5_no_resume", ev(0,0,0,0,0,0,0,0,0));
    start = 1'b1; rt = 5'd31;
    tick(); start = 1'b0; #1; chk("t5_single", ev(1,0,1,0,1,0,1,0,31));
    tick(); #1; chk("t5_done", ev(0,0,0,0,0,0,0,1,0));

    // 6: rt=0 full run, then start under hold in IDLE
    tick(); start = 1'b1; rt = 5'd0;
    for (int i = 0; i < 32; i++) begin
      tick(); start = 1'b0; #1;
      chk($sformatf("t6_b%0d", i),
          ev(1, (i != 31), 1, 0, (i == 0), (i != 0), (i == 31), 0, i));
    end
    tick(); #1; chk("t6_done", ev(0,0,0,0,0,0,0,1,0));
    tick(); start = 1'b1; hold = 1'b1; rt = 5'd5;
    tick(); start = 1'b0; hold = 1'b0; #1; chk("t6_hold_start", ev(0,0,0,0,0,0,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
